// File: rtl/conv_pool_pkg.sv
// Shared sizing helpers and saturation / max arithmetic for the conv + max-pool engine.
package conv_pool_pkg;

    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int calc_m(input int n, input int k);
        return n - k + 1;
    endfunction

    function automatic int calc_prod_w(input int img_w, input int ker_w);
        return img_w + 1 + ker_w;
    endfunction

    function automatic int calc_sum_w(input int prod_w, input int k);
        return prod_w + $clog2(k * k);
    endfunction

    function automatic wide_t acc_hi(input int acc_w);
        return (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t acc_lo(input int acc_w);
        return -acc_hi(acc_w) - wide_t'(1);
    endfunction

    function automatic wide_t sat_acc(input wide_t x, input int acc_w);
        wide_t r;
        r = x;
        if (x > acc_hi(acc_w)) begin
            r = acc_hi(acc_w);
        end else if (x < acc_lo(acc_w)) begin
            r = acc_lo(acc_w);
        end
        return r;
    endfunction

    function automatic logic sat_clamps(input wide_t x, input int acc_w);
        return (x > acc_hi(acc_w)) || (x < acc_lo(acc_w));
    endfunction

    function automatic wide_t max_acc(input wide_t a, input wide_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_pool_stream_dot.sv
// One output position: K*K registered pixel*weight products and their full-width sum.
module conv_window_dot
    import conv_pool_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int KER_W = 8,
    parameter int K     = 3
) (
    input  logic                                                      clk,
    input  logic                                                      en,
    input  logic [K*K*(IMG_W+1)-1:0]                                  win,
    input  logic [K*K*KER_W-1:0]                                      ker,
    output logic signed [calc_sum_w(calc_prod_w(IMG_W, KER_W), K)-1:0] sum
);

    localparam int PIX_W  = IMG_W + 1;
    localparam int PROD_W = calc_prod_w(IMG_W, KER_W);
    localparam int SUM_W  = calc_sum_w(PROD_W, K);

    logic signed [PROD_W-1:0] prod_p2 [K*K];

    // S1 -> S2: product register
    always_ff @(posedge clk) begin
        if (en) begin
            for (int t = 0; t < K*K; t++) begin
                prod_p2[t] <= $signed(win[t*PIX_W +: PIX_W]) * $signed(ker[t*KER_W +: KER_W]);
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int t = 0; t < K*K; t++) begin
            sum = sum + SUM_W'(prod_p2[t]);
        end
    end

endmodule

// File: rtl/conv_pool_stream.sv
// Streaming N x N tile convolution with saturating cross-channel accumulation,
// optional ReLU and global max-pool, valid/ready on both sides.
module conv_pool_stream
    import conv_pool_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int KER_W = 8,
    parameter int N     = 4,
    parameter int K     = 3,
    parameter int ACC_W = 24
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [N*N*IMG_W-1:0]                        in_image,
    input  logic [K*K*KER_W-1:0]                        in_kernel,
    input  logic                                        in_first,
    input  logic                                        in_last,
    input  logic                                        relu_en,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [calc_m(N,K)*calc_m(N,K)*ACC_W-1:0]    out_conv,
    output logic [ACC_W-1:0]                            out_pool,
    output logic                                        out_sat
);

    localparam int M     = calc_m(N, K);
    localparam int PIX_W = IMG_W + 1;
    localparam int SUM_W = calc_sum_w(calc_prod_w(IMG_W, KER_W), K);

    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // S1: operand register
    logic signed [PIX_W-1:0] pix_p1 [N*N];
    logic [K*K*KER_W-1:0]    ker_p1;
    logic                    vld_p1, first_p1, last_p1, relu_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            relu_p1  <= 1'b0;
        end else if (en) begin
            vld_p1   <= in_valid;
            first_p1 <= in_first;
            last_p1  <= in_last;
            relu_p1  <= relu_en;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int p = 0; p < N*N; p++) begin
                pix_p1[p] <= {1'b0, in_image[p*IMG_W +: IMG_W]};
            end
            ker_p1 <= in_kernel;
        end
    end

    // S2: products live inside each window unit
    logic                    vld_p2, first_p2, last_p2, relu_p2;
    logic signed [SUM_W-1:0] sum_p2 [M*M];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2   <= 1'b0;
            first_p2 <= 1'b0;
            last_p2  <= 1'b0;
            relu_p2  <= 1'b0;
        end else if (en) begin
            vld_p2   <= vld_p1;
            first_p2 <= first_p1;
            last_p2  <= last_p1;
            relu_p2  <= relu_p1;
        end
    end

    for (genvar r = 0; r < M; r++) begin : g_row
        for (genvar c = 0; c < M; c++) begin : g_col
            logic [K*K*PIX_W-1:0] win;
            for (genvar i = 0; i < K; i++) begin : g_wi
                for (genvar j = 0; j < K; j++) begin : g_wj
                    assign win[(i*K+j)*PIX_W +: PIX_W] = pix_p1[(r+i)*N + (c+j)];
                end
            end
            conv_window_dot #(
                .IMG_W (IMG_W),
                .KER_W (KER_W),
                .K     (K)
            ) u_dot (
                .clk (clk),
                .en  (en),
                .win (win),
                .ker (ker_p1),
                .sum (sum_p2[r*M+c])
            );
        end
    end

    // S3: saturating accumulate
    logic signed [ACC_W-1:0] acc_p3 [M*M];
    logic signed [ACC_W-1:0] acc_nxt [M*M];
    wide_t                   wsum [M*M];
    logic                    clamp_any;
    logic                    vld_p3, last_p3, relu_p3, sat_p3;

    always_comb begin
        clamp_any = 1'b0;
        for (int p = 0; p < M*M; p++) begin
            wsum[p]    = first_p2 ? WIDE_W'(sum_p2[p])
                                  : WIDE_W'(acc_p3[p]) + WIDE_W'(sum_p2[p]);
            acc_nxt[p] = ACC_W'(sat_acc(wsum[p], ACC_W));
            clamp_any  = clamp_any | sat_clamps(wsum[p], ACC_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p3  <= 1'b0;
            last_p3 <= 1'b0;
            relu_p3 <= 1'b0;
            sat_p3  <= 1'b0;
            for (int p = 0; p < M*M; p++) begin
                acc_p3[p] <= '0;
            end
        end else if (en) begin
            vld_p3  <= vld_p2;
            last_p3 <= last_p2;
            relu_p3 <= relu_p2;
            if (vld_p2) begin
                for (int p = 0; p < M*M; p++) begin
                    acc_p3[p] <= acc_nxt[p];
                end
                sat_p3 <= first_p2 ? clamp_any : (sat_p3 | clamp_any);
            end
        end
    end

    // Output register: ReLU, max-pool, handshake
    logic signed [ACC_W-1:0] rl [M*M];
    logic signed [ACC_W-1:0] pool_nxt;
    logic [M*M*ACC_W-1:0]    conv_nxt;

    always_comb begin
        conv_nxt = '0;
        for (int p = 0; p < M*M; p++) begin
            rl[p] = (relu_p3 && acc_p3[p] < 0) ? '0 : acc_p3[p];
            conv_nxt[p*ACC_W +: ACC_W] = rl[p];
        end
        pool_nxt = rl[0];
        for (int p = 1; p < M*M; p++) begin
            pool_nxt = ACC_W'(max_acc(WIDE_W'(pool_nxt), WIDE_W'(rl[p])));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_conv  <= '0;
            out_pool  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            if (vld_p3 && last_p3) begin
                out_valid <= 1'b1;
                out_conv  <= conv_nxt;
                out_pool  <= pool_nxt;
                out_sat   <= sat_p3;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_stream.sv
// Directed bench for conv_pool_stream: default-width and ACC_W=20 instances share stimulus,
// a queue-based reference model is checked every cycle, plus literal expectations per case.
module tb_conv_pool_stream;

    localparam int IMG_W = 8;
    localparam int KER_W = 8;
    localparam int N     = 4;
    localparam int K     = 3;
    localparam int M     = 2;
    localparam int ACC0  = 24;
    localparam int ACC1  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, relu_en = 1'b0;
    logic out_ready = 1'b1;
    logic [N*N*IMG_W-1:0] in_image = '0;
    logic [K*K*KER_W-1:0] in_kernel = '0;

    logic in_ready0, in_ready1, out_valid0, out_valid1, out_sat0, out_sat1;
    logic [M*M*ACC0-1:0] out_conv0;
    logic [M*M*ACC1-1:0] out_conv1;
    logic [ACC0-1:0]     out_pool0;
    logic [ACC1-1:0]     out_pool1;

    conv_pool_stream #(.IMG_W(IMG_W), .KER_W(KER_W), .N(N), .K(K), .ACC_W(ACC0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_image(in_image), .in_kernel(in_kernel), .in_first(in_first), .in_last(in_last),
        .relu_en(relu_en), .out_valid(out_valid0), .out_ready(out_ready),
        .out_conv(out_conv0), .out_pool(out_pool0), .out_sat(out_sat0)
    );

    conv_pool_stream #(.IMG_W(IMG_W), .KER_W(KER_W), .N(N), .K(K), .ACC_W(ACC1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_image(in_image), .in_kernel(in_kernel), .in_first(in_first), .in_last(in_last),
        .relu_en(relu_en), .out_valid(out_valid1), .out_ready(out_ready),
        .out_conv(out_conv1), .out_pool(out_pool1), .out_sat(out_sat1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: exact sums, per-width saturation, result queues
    typedef struct packed {
        logic [M*M-1:0][63:0] conv;
        logic [63:0]          pool;
        logic                 sat;
    } res_t;

    res_t   q0[$], q1[$];
    longint acc0[M*M], acc1[M*M];
    bit     flag0 = 1'b0, flag1 = 1'b0;

    function automatic longint satw(input longint x, input int w, output bit c);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        c = 1'b0;
        if (x > hi) begin c = 1'b1; return hi; end
        if (x < lo) begin c = 1'b1; return lo; end
        return x;
    endfunction

    function automatic longint conv_sum(input int r, input int c);
        longint s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += longint'(in_image[((r+i)*N + c + j)*IMG_W +: IMG_W]) *
                     longint'($signed(in_kernel[(i*K+j)*KER_W +: KER_W]));
        return s;
    endfunction

    function automatic res_t finish_group(input longint a[M*M], input bit relu, input bit flag);
        res_t   r = '0;
        longint v, mx = 0;
        for (int p = 0; p < M*M; p++) begin
            v = (relu && a[p] < 0) ? 0 : a[p];
            r.conv[p] = v;
            if (p == 0 || v > mx) mx = v;
        end
        r.pool = mx;
        r.sat  = flag;
        return r;
    endfunction

    task automatic model_beat();
        longint s;
        bit c;
        bit any0 = 1'b0, any1 = 1'b0;
        for (int p = 0; p < M*M; p++) begin
            s = conv_sum(p / M, p % M);
            acc0[p] = satw(in_first ? s : acc0[p] + s, ACC0, c); any0 |= c;
            acc1[p] = satw(in_first ? s : acc1[p] + s, ACC1, c); any1 |= c;
        end
        flag0 = in_first ? any0 : (flag0 | any0);
        flag1 = in_first ? any1 : (flag1 | any1);
        if (in_last) begin
            q0.push_back(finish_group(acc0, relu_en, flag0));
            q1.push_back(finish_group(acc1, relu_en, flag1));
        end
    endtask

    function automatic longint conv0(input int p);
        return longint'($signed(out_conv0[p*ACC0 +: ACC0]));
    endfunction

    function automatic longint conv1(input int p);
        return longint'($signed(out_conv1[p*ACC1 +: ACC1]));
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            q0.delete(); q1.delete();
            flag0 = 1'b0; flag1 = 1'b0;
            for (int p = 0; p < M*M; p++) begin acc0[p] = 0; acc1[p] = 0; end
            chk("rst_out_valid", out_valid0, 0);
            chk("rst_out_conv_zero", out_conv0 == '0, 1);
            chk("rst_out_pool", out_pool0, 0);
            chk("rst_out_sat", out_sat0, 0);
            chk("rst_in_ready", in_ready0, 1);
            chk("rst_out_valid1", out_valid1, 0);
            chk("rst_out_conv1_zero", out_conv1 == '0, 1);
        end else begin
            chk("in_ready_rule", in_ready0, !(out_valid0 && !out_ready));
            chk("in_ready_match", in_ready1, in_ready0);
            if (out_valid0) begin
                if (q0.size() == 0) chk("unexpected_out0", 1, 0);
                else begin
                    for (int p = 0; p < M*M; p++)
                        chk($sformatf("model_conv0[%0d]", p), conv0(p), longint'(q0[0].conv[p]));
                    chk("model_pool0", longint'($signed(out_pool0)), longint'(q0[0].pool));
                    chk("model_sat0", out_sat0, q0[0].sat);
                    if (out_ready) void'(q0.pop_front());
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) chk("unexpected_out1", 1, 0);
                else begin
                    for (int p = 0; p < M*M; p++)
                        chk($sformatf("model_conv1[%0d]", p), conv1(p), longint'(q1[0].conv[p]));
                    chk("model_pool1", longint'($signed(out_pool1)), longint'(q1[0].pool));
                    chk("model_sat1", out_sat1, q1[0].sat);
                    if (out_ready) void'(q1.pop_front());
                end
            end
            if (in_valid && in_ready0) model_beat();
        end
    end

    // Stimulus helpers
    task automatic set_img_const(input int v);
        for (int p = 0; p < N*N; p++) in_image[p*IMG_W +: IMG_W] = IMG_W'(v);
    endtask

    task automatic set_img_ramp();
        for (int p = 0; p < N*N; p++) in_image[p*IMG_W +: IMG_W] = IMG_W'(p);
    endtask

    task automatic set_ker_const(input int w);
        for (int t = 0; t < K*K; t++) in_kernel[t*KER_W +: KER_W] = KER_W'(w);
    endtask

    task automatic set_ker_centre();
        set_ker_const(0);
        in_kernel[4*KER_W +: KER_W] = KER_W'(1);
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send(input bit f, input bit l, input bit r);
        int n = 0;
        in_valid = 1'b1; in_first = f; in_last = l; relu_en = r;
        @(negedge clk);
        while (!in_ready0 && n < 50) begin @(negedge clk); n++; end
        if (!in_ready0) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid0 && lat < 20);
        if (!out_valid0) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic lit(input string nm, input longint e0, input longint e1, input longint e2,
                       input longint e3, input longint ep, input longint es);
        chk({nm, "_valid"}, out_valid0, 1);
        chk({nm, "_c00"}, conv0(0), e0);
        chk({nm, "_c01"}, conv0(1), e1);
        chk({nm, "_c10"}, conv0(2), e2);
        chk({nm, "_c11"}, conv0(3), e3);
        chk({nm, "_pool"}, longint'($signed(out_pool0)), ep);
        chk({nm, "_sat"}, out_sat0, es);
    endtask

    initial begin
        int lat;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", out_valid0, 0);
        chk("post_rst_ready", in_ready0, 1);

        // all-ones image and kernel, single beat group
        sync();
        set_img_const(1); set_ker_const(1);
        send(1, 1, 0);
        wait_valid(lat);
        chk("t1_latency", lat, 4);
        lit("t1", 9, 9, 9, 9, 9, 0);

        // ramp image, centre-tap kernel
        sync();
        set_img_ramp(); set_ker_centre();
        send(1, 1, 0);
        wait_valid(lat);
        lit("t2", 5, 6, 9, 10, 10, 0);

        // large negative results, then ReLU
        sync();
        set_img_const(255); set_ker_const(-128);
        send(1, 1, 0);
        wait_valid(lat);
        lit("t3_norelu", -293760, -293760, -293760, -293760, -293760, 0);
        sync();
        send(1, 1, 1);
        wait_valid(lat);
        lit("t3_relu", 0, 0, 0, 0, 0, 0);

        // three-beat channel group
        sync();
        set_img_const(1); set_ker_const(2);
        send(1, 0, 0);
        send(0, 0, 0);
        chk("t4_no_early", out_valid0, 0);
        send(0, 1, 0);
        wait_valid(lat);
        chk("t4_latency", lat, 4);
        lit("t4", 54, 54, 54, 54, 54, 0);

        // backpressure with two groups in flight
        sync();
        out_ready = 1'b0;
        set_img_const(1); set_ker_const(1);
        send(1, 1, 0);
        set_img_ramp(); set_ker_centre();
        send(1, 1, 0);
        wait_valid(lat);
        for (int s = 0; s < 5; s++) begin
            chk("t5_stall_ready", in_ready0, 0);
            chk("t5_stall_valid", out_valid0, 1);
            chk("t5_stall_pool", longint'($signed(out_pool0)), 9);
            @(negedge clk);
        end
        sync();
        out_ready = 1'b1;
        sync();
        lit("t5_second", 5, 6, 9, 10, 10, 0);
        sync();
        chk("t5_drained", out_valid0, 0);

        // saturation in the narrow instance
        set_img_const(255); set_ker_const(127);
        send(1, 0, 0);
        send(0, 1, 0);
        wait_valid(lat);
        lit("t6_wide", 582930, 582930, 582930, 582930, 582930, 0);
        chk("t6_sat_c00", conv1(0), 524287);
        chk("t6_sat_c11", conv1(3), 524287);
        chk("t6_sat_pool", longint'($signed(out_pool1)), 524287);
        chk("t6_sat_flag", out_sat1, 1);

        // reset in the middle of a group, then a fresh group
        sync();
        set_img_ramp(); set_ker_const(3);
        send(1, 0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("t7_rst_valid", out_valid0, 0);
        chk("t7_rst_pool", longint'(out_pool0), 0);
        chk("t7_rst_sat1", out_sat1, 0);
        set_ker_centre();
        send(1, 1, 0);
        wait_valid(lat);
        chk("t7_latency", lat, 4);
        lit("t7_after_rst", 5, 6, 9, 10, 10, 0);
        chk("t7_sat1_clear", out_sat1, 0);

        repeat (6) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_pool_stream.md
# conv_pool_stream

Parametrised streaming convolution + max-pool channel engine. Each accepted beat carries one N×N unsigned image tile and one K×K signed kernel. The block computes all M×M valid-position convolution sums (M = N−K+1) and accumulates them across input-channel beats with saturation. At the last beat of a group it applies optional ReLU and a global max-pool. It sits between the tile/weight fetch logic and the activation writeback, using valid/ready handshakes on both sides.

## Interface
Parameters:
- IMG_W, 8, image pixel width (unsigned)
- KER_W, 8, kernel weight width (signed two's complement)
- N, 4, input tile side; N ≥ K
- K, 3, kernel side
- ACC_W, 24, accumulator / output width (signed)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_image  in  N*N*IMG_W  pixel (r,c) at [(r*N+c)*IMG_W +: IMG_W]
- in_kernel  in  K*K*KER_W  weight (r,c) at [(r*K+c)*KER_W +: KER_W]
- in_first  in  1  beat starts a channel group (accumulator overwritten)
- in_last  in  1  beat ends a channel group (result emitted)
- relu_en  in  1  sampled with the in_last beat; clamps negative results to 0
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_conv  out  M*M*ACC_W  conv result (r,c) at [(r*M+c)*ACC_W +: ACC_W]
- out_pool  out  ACC_W  max over all M×M out_conv entries
- out_sat  out  1  some accumulation in this group saturated

## Operation
- S1 (operand register): pixels are zero-extended to IMG_W+1 signed; kernel, first/last and relu_en are registered.
- S2 (product register): M*M*K*K products. PROD_W = IMG_W+1+KER_W. Conv(r,c) uses pixel(r+i,c+j)*w(i,j).
- S3 (sum + accumulate): each position sums its K*K products at full width, SUM_W = PROD_W+ceil(log2(K*K)).
  - in_first: acc = sat(sum).
  - otherwise: acc = sat(acc + sum).
  - sat clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. The sat flag is set on any clamp and cleared on in_first.
  - in_last: the output register loads the result with ReLU applied when relu_en, plus out_pool, out_sat, and out_valid=1.
- Beats without in_last produce no output.
- A beat with both in_first and in_last is a single-channel group.
- A beat without in_first accumulates onto the current acc, whatever its history.
- Stall: en = !(out_valid && !out_ready); in_ready = en. While en=0, every stage register holds, including the accumulator.
- On output handshake with no new last beat in S3: out_valid → 0; out data holds its last value.

## Timing
- Reset (async assert, sync release): out_valid=0, out_conv=0, out_pool=0, out_sat=0. All pipeline valids, accumulators and the sat flag are cleared. in_ready=1 after reset.
- Latency: last beat accepted at edge t → out_valid high after edge t+3 when no stall.
- Throughput: 1 beat/cycle; back-to-back groups with no bubbles.
- Reset mid-group: the partial group is discarded. The next beat must carry in_first.
- Simultaneous output handshake and new last beat reaching S3: the output register reloads, and out_valid stays 1.

## Structure
- Package conv_pool_pkg: localparams-from-params helper functions (M, PROD_W, SUM_W), sat_acc() function, max() function.
- Sub-module conv_window_dot: K*K registered products plus full-width sum for one output position. Instantiated M*M times via generate; the stall enable is passed in.
- The top level holds S1, the accumulators, ReLU/pool and the handshake.

## Test plan
- Default params, image all 1, kernel all 1, first&last, relu off → out_conv all 9, out_pool 9, out_sat 0, out_valid 3 cycles after accept.
- Image pixel(r,c)=r*4+c, kernel centre=1, others 0 → out_conv [5,6,9,10], out_pool 10.
- Image all 255, kernel all −128 → relu off: all −293760, pool −293760; relu on: all 0, pool 0.
- Three beats first/–/last, image all 1, kernel all 2 → a single output with all 54; no out_valid on the first two beats.
- out_ready low 5 cycles with two groups in flight → in_ready low, out_* stable, both results delivered in order; no loss or duplication.
- ACC_W=20, two beats image 255, kernel 127 → 582930 clamps to 524287, out_sat=1. Then assert rst mid-group → outputs 0; a fresh single-beat group is correct.
